// File: rtl/tff_count_ctrl.sv
// Sequencer for the DE2 3-bit T-flip-flop counter: debounces the step/load keys,
// computes the toggle mask that moves q_fb to its next value and emits it for one cycle.
module tff_count_ctrl #(
   parameter int DEB_CYCLES = 16,
   parameter int AUTO_DIV   = 8
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       step_key_n,
   input  logic       load_key_n,
   input  logic [1:0] mode,
   input  logic [2:0] load_val,
   input  logic [2:0] q_fb,
   output logic [2:0] t_out,
   output logic       wrap,
   output logic       busy,
   output logic [1:0] dbg_state
);

   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int PW = $clog2(AUTO_DIV);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_FIRE = 2'd1, S_SETTLE = 2'd2} state_t;

   // Index 0 is the step key, index 1 the load key.
   logic [1:0]    key_raw;
   logic [1:0]    sync1_q, sync2_q, level_q, armed_q, press_q;
   logic [DW-1:0] deb_cnt_q [2];
   logic [PW-1:0] presc_q;
   logic          auto_tick;
   state_t        state_q;
   logic [2:0]    t_out_q;
   logic          wrap_q, busy_q;

   assign key_raw = {load_key_n, step_key_n};

   // Synchronisers restart at "pressed" so a key held through reset must be released
   // (arming it) before any press can be reported.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         level_q <= '1;
         armed_q <= '0;
         press_q <= '0;
         for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
      end else begin
         sync1_q <= key_raw;
         sync2_q <= sync1_q;
         for (int i = 0; i < 2; i++) begin
            press_q[i] <= 1'b0;
            if (sync2_q[i]) armed_q[i] <= 1'b1;
            if (sync2_q[i] == level_q[i]) begin
               deb_cnt_q[i] <= '0;
            end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
               deb_cnt_q[i] <= '0;
               level_q[i]   <= sync2_q[i];
               press_q[i]   <= level_q[i] & armed_q[i];
            end else begin
               deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset || mode != 2'b11)             presc_q <= '0;
      else if (presc_q == PW'(AUTO_DIV - 1)) presc_q <= '0;
      else                                   presc_q <= presc_q + PW'(1);
   end

   assign auto_tick = (mode == 2'b11) && (presc_q == PW'(AUTO_DIV - 1));

   // Gray successor: decode to binary, increment, re-encode.
   function automatic logic [2:0] next_val(input logic [1:0] m, input logic [2:0] q);
      logic [2:0] b, nb;
      b  = {q[2], q[2] ^ q[1], q[2] ^ q[1] ^ q[0]};
      nb = b + 3'd1;
      case (m)
         2'b01:   next_val = q - 3'd1;
         2'b10:   next_val = nb ^ (nb >> 1);
         default: next_val = q + 3'd1;
      endcase
   endfunction

   function automatic logic wraps(input logic [1:0] m, input logic [2:0] q);
      case (m)
         2'b01:   wraps = (q == 3'b000);
         2'b10:   wraps = (q == 3'b100);
         default: wraps = (q == 3'b111);
      endcase
   endfunction

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= S_IDLE;
         t_out_q <= '0;
         wrap_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (press_q[1]) begin
                  state_q <= S_FIRE;
                  t_out_q <= q_fb ^ load_val;
                  wrap_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end else if ((press_q[0] && mode != 2'b11) || auto_tick) begin
                  state_q <= S_FIRE;
                  t_out_q <= q_fb ^ next_val(mode, q_fb);
                  wrap_q  <= wraps(mode, q_fb);
                  busy_q  <= 1'b1;
               end
            end
            S_FIRE: begin
               state_q <= S_SETTLE;
               t_out_q <= '0;
               wrap_q  <= 1'b0;
               busy_q  <= 1'b1;
            end
            S_SETTLE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               t_out_q <= '0;
               wrap_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign t_out     = t_out_q;
   assign wrap      = wrap_q;
   assign busy      = busy_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Bench for tff_count_ctrl: models the T-FF counter, predicts each event's toggle mask
// from the sequence rules and checks it when the controller fires.
module tb_tff_count_ctrl;
   localparam int DEB  = 16;
   localparam int ADIV = 8;

   logic       clk = 1'b0;
   logic       reset, step_key_n, load_key_n;
   logic [1:0] mode;
   logic [2:0] load_val, q_fb, t_out;
   logic       wrap, busy;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   tff_count_ctrl #(.DEB_CYCLES(DEB), .AUTO_DIV(ADIV)) dut (
      .CLOCK_50(clk), .reset(reset), .step_key_n(step_key_n), .load_key_n(load_key_n),
      .mode(mode), .load_val(load_val), .q_fb(q_fb), .t_out(t_out), .wrap(wrap),
      .busy(busy), .dbg_state(dbg_state)
   );

   logic [3:0] exp_q[$];
   int         fire_cyc[$];
   int         n_cmp = 0, n_err = 0;
   int         cyc = 0, n_fire = 0, last_fall = 0;
   bit         mon_en = 1'b0;
   logic [2:0] q_exp;
   logic [2:0] gray_ring [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

   always @(posedge clk) cyc <= cyc + 1;

   // The counter flip-flops: toggle by t_out once per cycle, mid-cycle.
   initial forever begin
      @(negedge clk);
      if (t_out !== 3'bxxx) q_fb = q_fb ^ t_out;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference sequence: returns {wrap, toggle mask} and the successor value.
   function automatic logic [3:0] ref_step(input logic [1:0] m, input logic [2:0] q,
                                           output logic [2:0] n);
      int   v = int'(q);
      int   idx = 0;
      logic w;
      case (m)
         2'b01: begin n = 3'((v + 7) % 8); w = (v == 0); end
         2'b10: begin
            for (int i = 0; i < 8; i++) if (gray_ring[i] == q) idx = i;
            n = gray_ring[(idx + 1) % 8];
            w = (idx == 7);
         end
         default: begin n = 3'((v + 1) % 8); w = (v == 7); end
      endcase
      return {w, q ^ n};
   endfunction

   initial begin
      logic busy_prev = 1'b0;
      int   since = 99;
      logic [3:0] e;
      forever begin
         @(posedge clk); #1;
         if (mon_en) begin
            if (busy && !busy_prev) begin
               n_fire++;
               fire_cyc.push_back(cyc);
               since = 0;
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_event: t_out=%b wrap=%b, none expected", t_out, wrap);
               end else begin
                  e = exp_q.pop_front();
                  if ({wrap, t_out} !== e) begin
                     n_err++;
                     $display("FAIL event: got wrap=%b t_out=%b expected wrap=%b t_out=%b",
                              wrap, t_out, e[3], e[2:0]);
                  end
               end
            end else begin
               if (t_out !== 3'b000 || wrap !== 1'b0) begin
                  n_cmp++; n_err++;
                  $display("FAIL spurious_pulse: t_out=%b wrap=%b expected 000/0", t_out, wrap);
               end
               since++;
               if (since == 1) check("busy_settle", int'(busy), 1);
               if (since == 2) check("busy_idle", int'(busy), 0);
            end
            busy_prev = busy;
         end
      end
   end

   task automatic press(input bit use_step, input bit use_load, input int hold);
      @(negedge clk);
      if (use_step) step_key_n = 1'b0;
      if (use_load) load_key_n = 1'b0;
      last_fall = cyc;
      repeat (hold) @(negedge clk);
      step_key_n = 1'b1;
      load_key_n = 1'b1;
      repeat (DEB + 6) @(negedge clk);
   endtask

   task automatic set_q(input logic [2:0] v);
      @(negedge clk);
      q_fb  = v;
      q_exp = v;
   endtask

   task automatic do_step(input logic [1:0] m);
      logic [2:0] n;
      mode = m;
      exp_q.push_back(ref_step(m, q_exp, n));
      q_exp = n;
      press(1'b1, 1'b0, DEB + 4);
      check("q_after_step", int'(q_fb), int'(q_exp));
   endtask

   task automatic do_load(input logic [2:0] v);
      load_val = v;
      exp_q.push_back({1'b0, q_exp ^ v});
      q_exp = v;
      press(1'b0, 1'b1, DEB + 4);
      check("q_after_load", int'(q_fb), int'(q_exp));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, op, target, k;
      logic [2:0] n;
      step_key_n = 1'b0; load_key_n = 1'b0;
      mode = 2'b00; load_val = 3'b000; q_fb = 3'b000; q_exp = 3'b000;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_t_out", int'(t_out), 0);
      check("reset_wrap", int'(wrap), 0);
      check("reset_busy", int'(busy), 0);
      @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b1;

      repeat (3 * DEB) @(negedge clk);
      check("held_through_reset", n_fire, 0);
      step_key_n = 1'b1; load_key_n = 1'b1;
      repeat (DEB + 6) @(negedge clk);

      f0 = n_fire;
      press(1'b1, 1'b0, 10);
      check("short_press_ignored", n_fire - f0, 0);

      do_step(2'b00);
      check("press_latency", fire_cyc[$] - last_fall, DEB + 3);
      check("single_pulse", n_fire - f0, 1);

      set_q(3'b111);
      for (int i = 0; i < 4; i++) do_step(2'b00);
      check("up_sequence_end", int'(q_fb), 3);
      set_q(3'b000);
      do_step(2'b01);
      set_q(3'b010);
      do_step(2'b10);
      do_step(2'b10);
      check("gray_sequence_end", int'(q_fb), 7);
      set_q(3'b101);
      do_load(3'b011);

      set_q(3'b110);
      load_val = 3'b001;
      mode     = 2'b00;
      exp_q.push_back({1'b0, 3'b110 ^ 3'b001});
      q_exp = 3'b001;
      f0 = n_fire;
      press(1'b1, 1'b1, DEB + 4);
      check("load_beats_step_count", n_fire - f0, 1);
      check("load_beats_step_q", int'(q_fb), 1);

      for (int i = 0; i < 16; i++) begin
         if ($urandom_range(0, 3) == 0) set_q(3'($urandom_range(0, 7)));
         op = $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            if (op == 3) load_key_n = 1'b0; else step_key_n = 1'b0;
            repeat ($urandom_range(1, DEB - 4)) @(negedge clk);
            step_key_n = 1'b1; load_key_n = 1'b1;
            repeat (3) @(negedge clk);
         end
         if (op == 3) do_load(3'($urandom_range(0, 7)));
         else         do_step(2'(op));
      end

      set_q(3'b000);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(ref_step(2'b11, q_exp, n));
         q_exp = n;
      end
      target = n_fire + 8;
      @(negedge clk);
      mode = 2'b11;
      f0   = cyc;
      press(1'b1, 1'b0, DEB + 4);
      k = 0;
      while (n_fire < target && k < 200) begin
         @(posedge clk); #2;
         k++;
      end
      check("auto_eight_steps", n_fire, target);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      mode  = 2'b00;
      @(posedge clk); #1;
      check("reset_settle_t_out", int'(t_out), 0);
      check("reset_settle_busy", int'(busy), 0);
      @(negedge clk);
      reset = 1'b0;
      check("auto_first_tick", fire_cyc[fire_cyc.size() - 8] - f0, ADIV);
      for (int i = 7; i >= 1; i--)
         check("auto_spacing", fire_cyc[fire_cyc.size() - i] - fire_cyc[fire_cyc.size() - i - 1], ADIV);
      check("auto_end_q", int'(q_fb), 0);

      repeat (3 * ADIV) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
